// File: rtl/lime_pkg.sv
// Shared definitions for the lime multi-cycle controller: state and
// instruction-class encodings, datapath mux selects, ALU op codes and
// trap-cause codes.
package lime_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_LOAD_WB  = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  // Instruction class lives in the top three opcode bits.
  typedef enum logic [2:0] {
    CLS_ALU_R   = 3'b000,
    CLS_ALU_I   = 3'b001,
    CLS_LOAD    = 3'b010,
    CLS_STORE   = 3'b011,
    CLS_BRANCH  = 3'b100,
    CLS_JUMP    = 3'b101,
    CLS_HALT    = 3'b110,
    CLS_ILLEGAL = 3'b111
  } class_e;

  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_REG = 2'b01;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // States that wait on the memory handshake and are guarded by the timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // States whose return to FETCH completes (retires) an instruction.
  function automatic logic is_retire_state(input state_e s);
    return (s == S_ALU_WB) || (s == S_LOAD_WB) || (s == S_MEM_WR) ||
           (s == S_BRANCH) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/lime_mc_control_if.sv
// Signal bundle between the controller and the IR/memory/datapath side.
// master is the controller view, slave the datapath/environment view.
interface lime_mc_control_if #(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
);
  logic [OP_W-1:0]    input_control;
  logic               input_mem_ready;
  logic               input_stall;
  logic               input_resume;

  logic               output_control_PCWrite;
  logic               output_control_IoD;
  logic               output_control_MemR;
  logic               output_control_MemW;
  logic               output_control_IRWrite;
  logic               output_control_Mem2Reg;
  logic               output_control_RegWrite;
  logic               output_control_PCSrc;
  logic               output_control_branch;
  logic [1:0]         output_control_ALUSrcA;
  logic [1:0]         output_control_ALUSrcB;
  logic [1:0]         output_control_branchType;
  logic [ALUOP_W-1:0] output_control_ALUOp;

  logic               output_halted;
  logic               output_trap;
  logic [1:0]         output_trap_cause;
  logic [CNT_W-1:0]   output_instr_count;
  logic [3:0]         output_state;

  modport master (
    input  input_control, input_mem_ready, input_stall, input_resume,
    output output_control_PCWrite, output_control_IoD, output_control_MemR,
           output_control_MemW, output_control_IRWrite, output_control_Mem2Reg,
           output_control_RegWrite, output_control_PCSrc, output_control_branch,
           output_control_ALUSrcA, output_control_ALUSrcB,
           output_control_branchType, output_control_ALUOp,
           output_halted, output_trap, output_trap_cause,
           output_instr_count, output_state
  );

  modport slave (
    output input_control, input_mem_ready, input_stall, input_resume,
    input  output_control_PCWrite, output_control_IoD, output_control_MemR,
           output_control_MemW, output_control_IRWrite, output_control_Mem2Reg,
           output_control_RegWrite, output_control_PCSrc, output_control_branch,
           output_control_ALUSrcA, output_control_ALUSrcB,
           output_control_branchType, output_control_ALUOp,
           output_halted, output_trap, output_trap_cause,
           output_instr_count, output_state
  );
endinterface

// File: rtl/lime_wait_timer.sv
// Memory-wait watchdog: counts cycles spent waiting on the handshake and
// flags when the count reaches the configured limit.
module lime_wait_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  // Clear has priority over counting so a fresh wait always starts at zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == limit_i);

endmodule

// File: rtl/lime_mc_control.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory/
// write-back, drives the datapath control word, counts retired
// instructions, and traps on illegal opcodes or memory timeouts.
module lime_mc_control
  import lime_pkg::*;
#(
  parameter int OP_W     = 7,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    input_control,
  input  logic               input_mem_ready,
  input  logic               input_stall,
  input  logic               input_resume,
  output logic               output_control_PCWrite,
  output logic               output_control_IoD,
  output logic               output_control_MemR,
  output logic               output_control_MemW,
  output logic               output_control_IRWrite,
  output logic               output_control_Mem2Reg,
  output logic               output_control_RegWrite,
  output logic               output_control_PCSrc,
  output logic               output_control_branch,
  output logic [1:0]         output_control_ALUSrcA,
  output logic [1:0]         output_control_ALUSrcB,
  output logic [1:0]         output_control_branchType,
  output logic [ALUOP_W-1:0] output_control_ALUOp,
  output logic               output_halted,
  output logic               output_trap,
  output logic [1:0]         output_trap_cause,
  output logic [CNT_W-1:0]   output_instr_count,
  output logic [3:0]         output_state
);

  localparam int TW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instr_count_q;
  class_e           cls;
  logic             tmr_clear, tmr_enable, tmr_expired;
  logic             retire;

  // Opcode bits between the class field and the ALU/branch fields carry no
  // meaning for control; they are folded here to mark them as intentionally unused.
  logic             unused_opcode_bits;
  assign unused_opcode_bits = ^input_control;

  assign cls = class_e'(input_control[OP_W-1 -: 3]);

  // Next state and control word; stall and reset override at the end.
  always_comb begin
    state_d                   = state_q;
    cause_d                   = cause_q;
    output_control_PCWrite    = 1'b0;
    output_control_IoD        = 1'b0;
    output_control_MemR       = 1'b0;
    output_control_MemW       = 1'b0;
    output_control_IRWrite    = 1'b0;
    output_control_Mem2Reg    = 1'b0;
    output_control_RegWrite   = 1'b0;
    output_control_PCSrc      = 1'b0;
    output_control_branch     = 1'b0;
    output_control_ALUSrcA    = 2'b00;
    output_control_ALUSrcB    = 2'b00;
    output_control_branchType = 2'b00;
    output_control_ALUOp      = '0;

    case (state_q)
      S_FETCH: begin
        output_control_MemR = 1'b1;
        if (input_mem_ready) begin
          output_control_IRWrite = 1'b1;
          output_control_PCWrite = 1'b1;
          output_control_ALUSrcA = SRCA_PC;
          output_control_ALUSrcB = SRCB_ONE;
          output_control_ALUOp   = ALUOP_W'(ALUOP_ADD);
          state_d                = S_DECODE;
        end else if (tmr_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        // Speculative branch-target add while the class is resolved.
        output_control_ALUSrcA = SRCA_PC;
        output_control_ALUSrcB = SRCB_IMM;
        output_control_ALUOp   = ALUOP_W'(ALUOP_ADD);
        case (cls)
          CLS_ALU_R:  state_d = S_EXEC_R;
          CLS_ALU_I:  state_d = S_EXEC_I;
          CLS_LOAD:   state_d = S_MEM_ADDR;
          CLS_STORE:  state_d = S_MEM_ADDR;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JUMP:   state_d = S_JUMP;
          CLS_HALT:   state_d = S_HALT;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        output_control_ALUSrcA = SRCA_REG;
        output_control_ALUSrcB = SRCB_REG;
        output_control_ALUOp   = input_control[ALUOP_W-1:0];
        state_d                = S_ALU_WB;
      end
      S_EXEC_I: begin
        output_control_ALUSrcA = SRCA_REG;
        output_control_ALUSrcB = SRCB_IMM;
        output_control_ALUOp   = input_control[ALUOP_W-1:0];
        state_d                = S_ALU_WB;
      end
      S_ALU_WB: begin
        output_control_RegWrite = 1'b1;
        state_d                 = S_FETCH;
      end
      S_MEM_ADDR: begin
        output_control_ALUSrcA = SRCA_REG;
        output_control_ALUSrcB = SRCB_IMM;
        output_control_ALUOp   = ALUOP_W'(ALUOP_ADD);
        state_d                = (cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        output_control_IoD  = 1'b1;
        output_control_MemR = 1'b1;
        if (input_mem_ready) begin
          state_d = S_LOAD_WB;
        end else if (tmr_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        output_control_IoD  = 1'b1;
        output_control_MemW = 1'b1;
        if (input_mem_ready) begin
          state_d = S_FETCH;
        end else if (tmr_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_LOAD_WB: begin
        output_control_RegWrite = 1'b1;
        output_control_Mem2Reg  = 1'b1;
        state_d                 = S_FETCH;
      end
      S_BRANCH: begin
        output_control_ALUSrcA    = SRCA_REG;
        output_control_ALUSrcB    = SRCB_REG;
        output_control_ALUOp      = ALUOP_W'(ALUOP_SUB);
        output_control_branch     = 1'b1;
        output_control_branchType = input_control[1:0];
        output_control_PCSrc      = 1'b1;
        state_d                   = S_FETCH;
      end
      S_JUMP: begin
        output_control_PCWrite = 1'b1;
        output_control_PCSrc   = 1'b1;
        state_d                = S_FETCH;
      end
      S_HALT: begin
        if (input_resume) begin
          state_d = S_FETCH;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // A stall freezes sequencing and suppresses every write/access strobe,
    // even if memory reports ready in the same cycle.
    if (input_stall) begin
      state_d                 = state_q;
      cause_d                 = cause_q;
      output_control_PCWrite  = 1'b0;
      output_control_IRWrite  = 1'b0;
      output_control_RegWrite = 1'b0;
      output_control_MemR     = 1'b0;
      output_control_MemW     = 1'b0;
    end

    if (Reset) begin
      output_control_PCWrite    = 1'b0;
      output_control_IoD        = 1'b0;
      output_control_MemR       = 1'b0;
      output_control_MemW       = 1'b0;
      output_control_IRWrite    = 1'b0;
      output_control_Mem2Reg    = 1'b0;
      output_control_RegWrite   = 1'b0;
      output_control_PCSrc      = 1'b0;
      output_control_branch     = 1'b0;
      output_control_ALUSrcA    = 2'b00;
      output_control_ALUSrcB    = 2'b00;
      output_control_branchType = 2'b00;
      output_control_ALUOp      = '0;
    end
  end

  assign retire = !input_stall && (state_d == S_FETCH) && is_retire_state(state_q);

  // Timer restarts on every entry into a wait state and advances only while
  // actually waiting (not stalled, not ready).
  assign tmr_clear  = !input_stall && (state_d != state_q) && is_wait_state(state_d);
  assign tmr_enable = !input_stall && is_wait_state(state_q) && !input_mem_ready && !tmr_expired;

  lime_wait_timer #(.W(TW)) u_wait_timer (
    .clk       (CLK),
    .rst       (Reset),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_enable),
    .limit_i   (TW'(MAX_WAIT)),
    .expired_o (tmr_expired)
  );

  // State, trap cause and retired-instruction counter.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= S_FETCH;
      cause_q       <= CAUSE_NONE;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) begin
        instr_count_q <= instr_count_q + CNT_W'(1);
      end
    end
  end

  assign output_halted      = (state_q == S_HALT);
  assign output_trap        = (state_q == S_TRAP);
  assign output_trap_cause  = cause_q;
  assign output_instr_count = instr_count_q;
  assign output_state       = state_q;

endmodule

// File: tb/tb_lime_mc_control.sv
// Directed bench for lime_mc_control.
module tb_lime_mc_control;
  import lime_pkg::*;

  localparam int OP_W     = 7;
  localparam int ALUOP_W  = 3;
  localparam int CNT_W    = 16;
  localparam int MAX_WAIT = 15;

  localparam logic [6:0] OP_ADD_R = 7'b0000010;
  localparam logic [6:0] OP_ADDI  = 7'b0010101;
  localparam logic [6:0] OP_LOAD  = 7'b0100000;
  localparam logic [6:0] OP_STORE = 7'b0110000;
  localparam logic [6:0] OP_BR    = 7'b1000011;
  localparam logic [6:0] OP_JMP   = 7'b1010000;
  localparam logic [6:0] OP_HALT  = 7'b1100000;
  localparam logic [6:0] OP_ILL   = 7'b1110000;

  logic CLK = 1'b0;
  logic Reset;

  lime_mc_control_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  lime_mc_control #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK                       (CLK),
    .Reset                     (Reset),
    .input_control             (bus.input_control),
    .input_mem_ready           (bus.input_mem_ready),
    .input_stall               (bus.input_stall),
    .input_resume              (bus.input_resume),
    .output_control_PCWrite    (bus.output_control_PCWrite),
    .output_control_IoD        (bus.output_control_IoD),
    .output_control_MemR       (bus.output_control_MemR),
    .output_control_MemW       (bus.output_control_MemW),
    .output_control_IRWrite    (bus.output_control_IRWrite),
    .output_control_Mem2Reg    (bus.output_control_Mem2Reg),
    .output_control_RegWrite   (bus.output_control_RegWrite),
    .output_control_PCSrc      (bus.output_control_PCSrc),
    .output_control_branch     (bus.output_control_branch),
    .output_control_ALUSrcA    (bus.output_control_ALUSrcA),
    .output_control_ALUSrcB    (bus.output_control_ALUSrcB),
    .output_control_branchType (bus.output_control_branchType),
    .output_control_ALUOp      (bus.output_control_ALUOp),
    .output_halted             (bus.output_halted),
    .output_trap               (bus.output_trap),
    .output_trap_cause         (bus.output_trap_cause),
    .output_instr_count        (bus.output_instr_count),
    .output_state              (bus.output_state)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [OP_W-1:0] c, input logic rdy, input logic stl, input logic res);
    bus.input_control   = c;
    bus.input_mem_ready = rdy;
    bus.input_stall     = stl;
    bus.input_resume    = res;
    #1;
  endtask

  // From FETCH: complete the fetch and land in DECODE.
  task automatic fetch_decode(input logic [OP_W-1:0] c);
    drive(c, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    // Reset: outputs gated even though FETCH with ready would strobe.
    Reset = 1'b1;
    drive(OP_ADD_R, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check_eq("rst_state", bus.output_state, S_FETCH);
    check_eq("rst_count", bus.output_instr_count, 0);
    check_eq("rst_trap", bus.output_trap, 0);
    check_eq("rst_cause", bus.output_trap_cause, 0);
    check_eq("rst_halted", bus.output_halted, 0);
    check_eq("rst_memr_gated", bus.output_control_MemR, 0);
    check_eq("rst_irwrite_gated", bus.output_control_IRWrite, 0);

    // ALU-R instruction through to retirement.
    Reset = 1'b0;
    drive(OP_ADD_R, 1'b1, 1'b0, 1'b0);
    check_eq("fetch_memr", bus.output_control_MemR, 1);
    check_eq("fetch_iod", bus.output_control_IoD, 0);
    check_eq("fetch_irwrite", bus.output_control_IRWrite, 1);
    check_eq("fetch_pcwrite", bus.output_control_PCWrite, 1);
    check_eq("fetch_srcb", bus.output_control_ALUSrcB, 2'b01);
    tick();
    check_eq("dec_state", bus.output_state, S_DECODE);
    check_eq("dec_srcb", bus.output_control_ALUSrcB, 2'b10);
    tick();
    check_eq("execr_state", bus.output_state, S_EXEC_R);
    check_eq("execr_aluop", bus.output_control_ALUOp, 3'b010);
    check_eq("execr_srca", bus.output_control_ALUSrcA, 2'b01);
    check_eq("execr_srcb", bus.output_control_ALUSrcB, 2'b00);
    tick();
    check_eq("aluwb_state", bus.output_state, S_ALU_WB);
    check_eq("aluwb_regwrite", bus.output_control_RegWrite, 1);
    check_eq("aluwb_mem2reg", bus.output_control_Mem2Reg, 0);
    check_eq("aluwb_count", bus.output_instr_count, 0);
    tick();
    check_eq("r_ret_state", bus.output_state, S_FETCH);
    check_eq("r_ret_count", bus.output_instr_count, 1);

    // LOAD with three not-ready cycles in MEM_RD.
    fetch_decode(OP_LOAD);
    tick();
    check_eq("memaddr_state", bus.output_state, S_MEM_ADDR);
    check_eq("memaddr_srcb", bus.output_control_ALUSrcB, 2'b10);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(OP_LOAD, (i == 3), 1'b0, 1'b0);
      check_eq("memrd_state", bus.output_state, S_MEM_RD);
      check_eq("memrd_memr", bus.output_control_MemR, 1);
      check_eq("memrd_iod", bus.output_control_IoD, 1);
      tick();
    end
    check_eq("loadwb_state", bus.output_state, S_LOAD_WB);
    check_eq("loadwb_mem2reg", bus.output_control_Mem2Reg, 1);
    check_eq("loadwb_regwrite", bus.output_control_RegWrite, 1);
    tick();
    check_eq("load_ret_count", bus.output_instr_count, 2);

    // STORE: stall with ready in MEM_WR holds, release completes.
    fetch_decode(OP_STORE);
    tick();
    tick();
    drive(OP_STORE, 1'b1, 1'b1, 1'b0);
    check_eq("memwr_state", bus.output_state, S_MEM_WR);
    check_eq("memwr_stall_memw", bus.output_control_MemW, 0);
    check_eq("memwr_stall_iod", bus.output_control_IoD, 1);
    tick();
    check_eq("memwr_held", bus.output_state, S_MEM_WR);
    check_eq("memwr_held_count", bus.output_instr_count, 2);
    drive(OP_STORE, 1'b1, 1'b0, 1'b0);
    check_eq("memwr_memw", bus.output_control_MemW, 1);
    tick();
    check_eq("store_ret_state", bus.output_state, S_FETCH);
    check_eq("store_ret_count", bus.output_instr_count, 3);

    // BRANCH.
    fetch_decode(OP_BR);
    tick();
    check_eq("br_state", bus.output_state, S_BRANCH);
    check_eq("br_branch", bus.output_control_branch, 1);
    check_eq("br_type", bus.output_control_branchType, 2'b11);
    check_eq("br_pcsrc", bus.output_control_PCSrc, 1);
    check_eq("br_aluop", bus.output_control_ALUOp, 3'b001);
    check_eq("br_srca", bus.output_control_ALUSrcA, 2'b01);
    tick();
    check_eq("br_ret_count", bus.output_instr_count, 4);

    // JUMP.
    fetch_decode(OP_JMP);
    tick();
    check_eq("jmp_state", bus.output_state, S_JUMP);
    check_eq("jmp_pcwrite", bus.output_control_PCWrite, 1);
    check_eq("jmp_pcsrc", bus.output_control_PCSrc, 1);
    tick();
    check_eq("jmp_ret_count", bus.output_instr_count, 5);

    // ALU-I.
    fetch_decode(OP_ADDI);
    tick();
    check_eq("execi_state", bus.output_state, S_EXEC_I);
    check_eq("execi_aluop", bus.output_control_ALUOp, 3'b101);
    check_eq("execi_srcb", bus.output_control_ALUSrcB, 2'b10);
    tick();
    tick();
    check_eq("i_ret_count", bus.output_instr_count, 6);

    // HALT for five cycles, resume in the fifth.
    fetch_decode(OP_HALT);
    tick();
    check_eq("halt_state", bus.output_state, S_HALT);
    for (int i = 0; i < 5; i++) begin
      drive(OP_HALT, 1'b1, 1'b0, (i == 4));
      check_eq("halt_halted", bus.output_halted, 1);
      check_eq("halt_memr", bus.output_control_MemR, 0);
      tick();
    end
    check_eq("resume_state", bus.output_state, S_FETCH);
    check_eq("resume_halted", bus.output_halted, 0);
    check_eq("resume_count", bus.output_instr_count, 6);
    drive(OP_HALT, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("resume_ignored", bus.output_state, S_FETCH);

    // Reset in the middle of MEM_RD.
    fetch_decode(OP_LOAD);
    tick();
    tick();
    drive(OP_LOAD, 1'b0, 1'b0, 1'b0);
    check_eq("mid_memrd_state", bus.output_state, S_MEM_RD);
    Reset = 1'b1;
    #1;
    check_eq("mid_rst_memr", bus.output_control_MemR, 0);
    tick();
    check_eq("mid_rst_state", bus.output_state, S_FETCH);
    check_eq("mid_rst_count", bus.output_instr_count, 0);

    // Memory timeout in FETCH: 16 waiting cycles, then TRAP.
    Reset = 1'b0;
    drive(OP_LOAD, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < MAX_WAIT + 1; i++) begin
      check_eq("to_fetch_wait", bus.output_state, S_FETCH);
      tick();
    end
    check_eq("to_state", bus.output_state, S_TRAP);
    check_eq("to_trap", bus.output_trap, 1);
    check_eq("to_cause", bus.output_trap_cause, 2'b10);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check_eq("to_rst_state", bus.output_state, S_FETCH);
    check_eq("to_rst_cause", bus.output_trap_cause, 2'b00);

    // Illegal opcode traps after DECODE and ignores ready/resume.
    fetch_decode(OP_ILL);
    check_eq("ill_dec_state", bus.output_state, S_DECODE);
    tick();
    check_eq("ill_state", bus.output_state, S_TRAP);
    check_eq("ill_cause", bus.output_trap_cause, 2'b01);
    drive(OP_ILL, 1'b1, 1'b0, 1'b1);
    check_eq("ill_memr", bus.output_control_MemR, 0);
    check_eq("ill_irwrite", bus.output_control_IRWrite, 0);
    tick();
    tick();
    check_eq("ill_held", bus.output_state, S_TRAP);
    check_eq("ill_cause_held", bus.output_trap_cause, 2'b01);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check_eq("ill_rst_state", bus.output_state, S_FETCH);
    check_eq("ill_rst_trap", bus.output_trap, 0);
    check_eq("ill_rst_cause", bus.output_trap_cause, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lime_mc_control.md
LIME_MC_CONTROL -- requirements
Module: lime_mc_control

Interface
REQ-001 SHALL have parameters (name, default, meaning): OP_W, 7, opcode width, minimum 5; ALUOP_W, 3, ALU operation width; CNT_W, 16, retired-instruction counter width; MAX_WAIT, 15, memory wait cycles allowed before trap.
REQ-002 SHALL have ports (name  direction  width  meaning): CLK  in  1  clock; Reset  in  1  synchronous active-high reset.
REQ-003 SHALL have inputs: input_control  in  OP_W  opcode from IR; input_mem_ready  in  1  memory completes access; input_stall  in  1  freeze request; input_resume  in  1  leave HALT.
REQ-004 SHALL have outputs: output_control_PCWrite, _IoD, _MemR, _MemW, _IRWrite, _Mem2Reg, _RegWrite, _PCSrc, _branch (1 each); _ALUSrcA, _ALUSrcB, _branchType (2 each); _ALUOp (ALUOP_W).
REQ-005 SHALL have status outputs: output_halted (1), output_trap (1), output_trap_cause (2: 01 illegal opcode, 10 memory timeout), output_instr_count (CNT_W), output_state (4).
REQ-006 SHALL use one clock, CLK; reset is synchronous and active-high on Reset.

Function
REQ-007 SHALL decode class = input_control[OP_W-1:OP_W-3]: 000 ALU-R, 001 ALU-I, 010 LOAD, 011 STORE, 100 BRANCH, 101 JUMP, 110 HALT, 111 illegal.
REQ-008 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WR, LOAD_WB, BRANCH, JUMP, HALT, TRAP.
REQ-009 FETCH: MemR=1, IoD=0; stay until mem_ready; on mem_ready IRWrite=1, PCWrite=1, ALUSrcA=00 (PC), ALUSrcB=01 (+1), ALUOp=ADD, next DECODE.
REQ-010 DECODE: ALUSrcA=00, ALUSrcB=10 (imm), ALUOp=ADD; next by class per REQ-007; LOAD/STORE -> MEM_ADDR; illegal -> TRAP, cause 01.
REQ-011 EXEC_R: ALUSrcA=01 (A), ALUSrcB=00 (B); EXEC_I: ALUSrcA=01, ALUSrcB=10; both ALUOp=input_control[ALUOP_W-1:0], next ALU_WB.
REQ-012 ALU_WB: RegWrite=1, Mem2Reg=0, next FETCH; LOAD_WB: RegWrite=1, Mem2Reg=1, next FETCH.
REQ-013 MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=ADD; next MEM_RD (LOAD) or MEM_WR (STORE).
REQ-014 MEM_RD: IoD=1, MemR=1 until mem_ready, then LOAD_WB; MEM_WR: IoD=1, MemW=1 until mem_ready, then FETCH.
REQ-015 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=SUB, branch=1, branchType=input_control[1:0], PCSrc=1; next FETCH.
REQ-016 JUMP: PCWrite=1, PCSrc=1; next FETCH. HALT: output_halted=1, all enables 0; on input_resume next FETCH.
REQ-017 TRAP: output_trap=1, all enables 0, cause held; exit only by Reset.
REQ-018 Unlisted outputs in any state SHALL be 0; outputs are combinational from state, opcode, mem_ready, stall.
REQ-019 Wait counter SHALL clear on entry to FETCH, MEM_RD, MEM_WR and increment each cycle there without mem_ready; at count == MAX_WAIT without mem_ready, next state TRAP, cause 10.
REQ-020 input_stall=1 SHALL hold state and wait counter and force PCWrite, IRWrite, RegWrite, MemR, MemW to 0; stall wins over simultaneous mem_ready, which is then ignored.
REQ-021 output_instr_count SHALL increment by 1 on each transition into FETCH from ALU_WB, LOAD_WB, MEM_WR, BRANCH, JUMP, wrapping at 2^CNT_W.
REQ-022 input_resume outside HALT SHALL be ignored.

Reset
REQ-023 On a CLK edge with Reset=1: state=FETCH, wait counter=0, instr_count=0, trap=0, cause=00, halted=0, regardless of current state.
REQ-024 While Reset=1 all control outputs SHALL be 0.

Structure
REQ-025 Package lime_pkg SHALL hold the state enum, class codes, ALUSrcA/B encodings, ALUOp ADD=000 and SUB=001, trap-cause codes.
REQ-026 Wait counter SHALL be sub-module lime_wait_timer (clear, enable, limit, expired).

Verification
REQ-027 ALU-R opcode 0000010, mem_ready=1 in FETCH -> FETCH, DECODE, EXEC_R (ALUOp=010), ALU_WB (RegWrite=1), FETCH; instr_count 0->1.
REQ-028 LOAD, mem_ready low 3 cycles in MEM_RD -> MemR=1 and IoD=1 held 4 cycles, then LOAD_WB with Mem2Reg=1.
REQ-029 mem_ready never asserted in FETCH, MAX_WAIT=15 -> TRAP after 16 FETCH cycles, cause 10; Reset returns to FETCH.
REQ-030 Opcode 1110000 -> TRAP after DECODE, cause 01; mem_ready and resume ignored.
REQ-031 Stall asserted with mem_ready in MEM_WR -> MemW=0, state held; stall released with mem_ready -> FETCH.
REQ-032 HALT opcode then resume after 5 cycles -> halted=1 for 5 cycles, then FETCH; Reset mid-MEM_RD -> FETCH, count=0.
